// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MIPS32 memory-access stage: op codes, bus payload
// and small op-classification helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CNT_W      = 8;

  typedef logic [ALU_OP_W-1:0]   alu_op_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic              RstEnable = 1'b1;
  localparam logic [DATA_W-1:0] ZeroWord  = 32'h0000_0000;

  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LWL_OP = 8'b1110_0010;
  localparam alu_op_t EXE_LWR_OP = 8'b1110_0110;
  localparam alu_op_t EXE_LL_OP  = 8'b1111_0000;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;
  localparam alu_op_t EXE_SWL_OP = 8'b1110_1010;
  localparam alu_op_t EXE_SWR_OP = 8'b1110_1110;
  localparam alu_op_t EXE_SC_OP  = 8'b1111_1000;

  // Bus command held stable for the whole REQ phase
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  function automatic logic is_load_op(input alu_op_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_LWL_OP, EXE_LWR_OP, EXE_LL_OP: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input alu_op_t op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP,
      EXE_SC_OP: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic is_partial_word_op(input alu_op_t op);
    case (op)
      EXE_LWL_OP, EXE_LWR_OP, EXE_SWL_OP, EXE_SWR_OP: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input alu_op_t op, input logic [1:0] off);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:         return off[0];
      EXE_LW_OP, EXE_LL_OP, EXE_SC_OP, EXE_SW_OP: return off != 2'b00;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store select/data generation and load extraction/merge
// for either endianness.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  alu_op_t           op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [SEL_W-1:0]  sel_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] load_data_c
);

  logic [1:0]        byte_lane;
  logic [1:0]        half_lane;
  logic [1:0]        k;
  logic [4:0]        k_sh;
  logic [4:0]        rk_sh;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] low_mask;
  logic [DATA_W-1:0] lwl_val;
  logic [DATA_W-1:0] lwr_val;

  // k is the big-endian-equivalent offset; little-endian mirrors the word
  always_comb begin
    byte_lane = BIG_ENDIAN ? ~offset : offset;
    half_lane = BIG_ENDIAN ? {~offset[1], 1'b0} : {offset[1], 1'b0};
    k         = BIG_ENDIAN ? offset : ~offset;
    k_sh      = {k, 3'b000};
    rk_sh     = {~k, 3'b000};
    byte_val  = rdata[{byte_lane, 3'b000} +: 8];
    half_val  = rdata[{half_lane, 3'b000} +: 16];
    low_mask  = ~(32'hFFFF_FFFF << k_sh);
    lwl_val   = (rdata << k_sh) | (reg_data & low_mask);
    lwr_val   = (rdata >> rk_sh) | (reg_data & ~(32'hFFFF_FFFF >> rk_sh));
  end

  always_comb begin
    sel_c       = '0;
    wdata_c     = '0;
    load_data_c = rdata;
    case (op)
      EXE_LB_OP:  begin sel_c = 4'b0001 << byte_lane; load_data_c = {{24{byte_val[7]}}, byte_val}; end
      EXE_LBU_OP: begin sel_c = 4'b0001 << byte_lane; load_data_c = {24'h0, byte_val}; end
      EXE_LH_OP:  begin sel_c = 4'b0011 << half_lane; load_data_c = {{16{half_val[15]}}, half_val}; end
      EXE_LHU_OP: begin sel_c = 4'b0011 << half_lane; load_data_c = {16'h0, half_val}; end
      EXE_LW_OP, EXE_LL_OP: sel_c = 4'b1111;
      EXE_LWL_OP: begin sel_c = 4'b1111 >> k; load_data_c = lwl_val; end
      EXE_LWR_OP: begin sel_c = 4'b1111 << ~k; load_data_c = lwr_val; end
      EXE_SB_OP:  begin sel_c = 4'b0001 << byte_lane; wdata_c = {4{reg_data[7:0]}}; end
      EXE_SH_OP:  begin sel_c = 4'b0011 << half_lane; wdata_c = {2{reg_data[15:0]}}; end
      EXE_SW_OP, EXE_SC_OP: begin sel_c = 4'b1111; wdata_c = reg_data; end
      EXE_SWL_OP: begin sel_c = 4'b1111 >> k; wdata_c = reg_data >> k_sh; end
      EXE_SWR_OP: begin sel_c = 4'b1111 << ~k; wdata_c = reg_data << rk_sh; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MIPS32 MEM stage: issues one request/acknowledge bus transfer per memory op,
// stalls the pipeline until it completes, and formats the write-back result.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  alu_op_t           aluop_in,
  input  logic [DATA_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] src2_data_in,
  input  logic [DATA_W-1:0] dest_data_in,
  input  reg_addr_t         dest_addr_in,
  input  logic              wreg_in,
  input  logic              llbit_in,
  input  logic              wb_llbit_we_in,
  input  logic              wb_llbit_data_in,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              stall_req,
  output reg_addr_t         dest_addr_out,
  output logic              wreg_out,
  output logic [DATA_W-1:0] dest_data_out,
  output logic              llbit_we_out,
  output logic              llbit_data_out,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_bus_err,
  output logic [DATA_W-1:0] bad_vaddr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  reg_addr_t         dest_addr_q, dest_addr_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] dest_data_q, dest_data_d;
  bus_cmd_t          bus_q, bus_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              link_eff;
  logic              in_mem;
  logic              in_misal;
  logic              in_sc_fail;
  logic              start;
  logic [CNT_W-1:0]  cnt_inc;
  alu_op_t           al_op;
  logic [1:0]        al_off;
  logic [DATA_W-1:0] al_data;
  logic [SEL_W-1:0]  al_sel;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;

  always_comb begin
    link_eff   = wb_llbit_we_in ? wb_llbit_data_in : llbit_in;
    in_mem     = is_load_op(aluop_in) | is_store_op(aluop_in);
    in_misal   = is_misaligned(aluop_in, mem_addr_in[1:0]);
    in_sc_fail = (aluop_in == EXE_SC_OP) && !link_eff;
    start      = (state_q == IDLE) && in_mem && !in_misal && !in_sc_fail;
    cnt_inc    = cnt_q + 8'd1;
    // Aligner sees the incoming op while idle, the latched op otherwise
    al_op      = (state_q == IDLE) ? aluop_in          : op_q;
    al_off     = (state_q == IDLE) ? mem_addr_in[1:0]  : addr_q[1:0];
    al_data    = (state_q == IDLE) ? src2_data_in      : merge_q;
  end

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op          (al_op),
    .offset      (al_off),
    .reg_data    (al_data),
    .rdata       (rdata_q),
    .sel_c       (al_sel),
    .wdata_c     (al_wdata),
    .load_data_c (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      merge_q     <= '0;
      dest_addr_q <= '0;
      wreg_q      <= 1'b0;
      dest_data_q <= '0;
      bus_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      merge_q     <= merge_d;
      dest_addr_q <= dest_addr_d;
      wreg_q      <= wreg_d;
      dest_data_q <= dest_data_d;
      bus_q       <= bus_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next state and latched transaction context
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    merge_d     = merge_q;
    dest_addr_d = dest_addr_q;
    wreg_d      = wreg_q;
    dest_data_d = dest_data_q;
    bus_d       = bus_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = REQ;
          op_d        = aluop_in;
          addr_d      = mem_addr_in;
          merge_d     = src2_data_in;
          dest_addr_d = dest_addr_in;
          wreg_d      = wreg_in;
          dest_data_d = dest_data_in;
          bus_d.we    = is_store_op(aluop_in);
          bus_d.sel   = al_sel;
          bus_d.wdata = al_wdata;
          bus_d.addr  = is_partial_word_op(aluop_in) ? {mem_addr_in[31:2], 2'b00}
                                                     : mem_addr_in;
          cnt_d       = '0;
          rdata_d     = ZeroWord;
          bus_err_d   = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          bus_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage outputs
  always_comb begin
    bus_req        = 1'b0;
    bus_we         = bus_q.we;
    bus_addr       = bus_q.addr;
    bus_sel        = bus_q.sel;
    bus_wdata      = bus_q.wdata;
    stall_req      = 1'b0;
    dest_addr_out  = dest_addr_in;
    wreg_out       = wreg_in;
    dest_data_out  = dest_data_in;
    llbit_we_out   = 1'b0;
    llbit_data_out = 1'b0;
    exc_adel       = 1'b0;
    exc_ades       = 1'b0;
    exc_bus_err    = 1'b0;
    bad_vaddr      = ZeroWord;
    case (state_q)
      IDLE: begin
        if (in_mem) begin
          if (in_misal) begin
            exc_adel  = is_load_op(aluop_in);
            exc_ades  = is_store_op(aluop_in);
            bad_vaddr = mem_addr_in;
            wreg_out  = 1'b0;
          end else if (in_sc_fail) begin
            dest_data_out = ZeroWord;
          end else begin
            stall_req = 1'b1;
            wreg_out  = 1'b0;
          end
        end
      end
      REQ: begin
        bus_req       = 1'b1;
        stall_req     = 1'b1;
        dest_addr_out = dest_addr_q;
        wreg_out      = 1'b0;
        dest_data_out = ZeroWord;
      end
      DONE: begin
        dest_addr_out = dest_addr_q;
        wreg_out      = wreg_q;
        dest_data_out = is_load_op(op_q) ? al_load : dest_data_q;
        if (op_q == EXE_LL_OP) begin
          llbit_we_out   = 1'b1;
          llbit_data_out = 1'b1;
        end else if (op_q == EXE_SC_OP) begin
          dest_data_out  = 32'h0000_0001;
          llbit_we_out   = 1'b1;
          llbit_data_out = 1'b0;
        end
        if (bus_err_q) begin
          exc_bus_err  = 1'b1;
          bad_vaddr    = addr_q;
          wreg_out     = 1'b0;
          llbit_we_out = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: big- and little-endian instances share
// stimulus; expected values are hand-computed per vector.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  alu_op_t     aluop_in;
  logic [31:0] mem_addr_in, src2_data_in, dest_data_in, bus_rdata;
  reg_addr_t   dest_addr_in;
  logic        wreg_in, llbit_in, wb_llbit_we_in, wb_llbit_data_in, bus_ack;

  logic        bus_req_be, bus_we_be, stall_be, wreg_be, llwe_be, lldata_be;
  logic        adel_be, ades_be, buserr_be;
  logic [31:0] bus_addr_be, bus_wdata_be, dest_be, bad_be;
  logic [3:0]  bus_sel_be;
  reg_addr_t   dest_addr_be;

  logic        bus_req_le, bus_we_le, stall_le, wreg_le, llwe_le, lldata_le;
  logic        adel_le, ades_le, buserr_le;
  logic [31:0] bus_addr_le, bus_wdata_le, dest_le, bad_le;
  logic [3:0]  bus_sel_le;
  reg_addr_t   dest_addr_le;

  int n_pass = 0;
  int n_total = 0;

  // Captured per transaction by run_op
  int          c_stall, c_req;
  logic        c_done, c_we;
  logic [3:0]  c_sel_be, c_sel_le;
  logic [31:0] c_addr, c_wdata_be, c_wdata_le;
  logic [31:0] r_dest_be, r_dest_le, r_bad;
  logic        r_wreg, r_llwe, r_lldata, r_adel, r_ades, r_buserr;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BIG_ENDIAN(1'b1), .TIMEOUT(4)) u_dut_be (
    .clk(clk), .rst(rst), .aluop_in(aluop_in), .mem_addr_in(mem_addr_in),
    .src2_data_in(src2_data_in), .dest_data_in(dest_data_in),
    .dest_addr_in(dest_addr_in), .wreg_in(wreg_in), .llbit_in(llbit_in),
    .wb_llbit_we_in(wb_llbit_we_in), .wb_llbit_data_in(wb_llbit_data_in),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_req(bus_req_be),
    .bus_we(bus_we_be), .bus_addr(bus_addr_be), .bus_sel(bus_sel_be),
    .bus_wdata(bus_wdata_be), .stall_req(stall_be), .dest_addr_out(dest_addr_be),
    .wreg_out(wreg_be), .dest_data_out(dest_be), .llbit_we_out(llwe_be),
    .llbit_data_out(lldata_be), .exc_adel(adel_be), .exc_ades(ades_be),
    .exc_bus_err(buserr_be), .bad_vaddr(bad_be)
  );

  mem_access_ctrl #(.BIG_ENDIAN(1'b0), .TIMEOUT(4)) u_dut_le (
    .clk(clk), .rst(rst), .aluop_in(aluop_in), .mem_addr_in(mem_addr_in),
    .src2_data_in(src2_data_in), .dest_data_in(dest_data_in),
    .dest_addr_in(dest_addr_in), .wreg_in(wreg_in), .llbit_in(llbit_in),
    .wb_llbit_we_in(wb_llbit_we_in), .wb_llbit_data_in(wb_llbit_data_in),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_req(bus_req_le),
    .bus_we(bus_we_le), .bus_addr(bus_addr_le), .bus_sel(bus_sel_le),
    .bus_wdata(bus_wdata_le), .stall_req(stall_le), .dest_addr_out(dest_addr_le),
    .wreg_out(wreg_le), .dest_data_out(dest_le), .llbit_we_out(llwe_le),
    .llbit_data_out(lldata_le), .exc_adel(adel_le), .exc_ades(ades_le),
    .exc_bus_err(buserr_le), .bad_vaddr(bad_le)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one op and runs it to completion; bus_ack rises after 'waits' REQ cycles
  task automatic run_op(input alu_op_t op, input logic [31:0] addr, input logic [31:0] src2,
                        input int waits, input logic [31:0] rdata);
    aluop_in = op; mem_addr_in = addr; src2_data_in = src2; bus_ack = 1'b0;
    c_stall = 0; c_req = 0; c_done = 1'b0;
    for (int cyc = 0; cyc < 20 && !c_done; cyc++) begin
      #1;
      if (bus_req_be) begin
        c_req++;
        c_we = bus_we_be; c_addr = bus_addr_be; c_sel_be = bus_sel_be; c_sel_le = bus_sel_le;
        c_wdata_be = bus_wdata_be; c_wdata_le = bus_wdata_le;
        if (c_req > waits) begin bus_ack = 1'b1; bus_rdata = rdata; end
      end
      if (stall_be) c_stall++;
      else begin
        c_done = 1'b1;
        r_dest_be = dest_be; r_dest_le = dest_le; r_wreg = wreg_be; r_bad = bad_be;
        r_llwe = llwe_be; r_lldata = lldata_be; r_adel = adel_be; r_ades = ades_be;
        r_buserr = buserr_be;
      end
      tick();
      bus_ack = 1'b0;
    end
    aluop_in = 8'h00;
    check("op_completed", 32'(c_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; aluop_in = 8'h00; mem_addr_in = '0; src2_data_in = '0;
    dest_data_in = '0; dest_addr_in = 5'd0; wreg_in = 1'b0; llbit_in = 1'b0;
    wb_llbit_we_in = 1'b0; wb_llbit_data_in = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_bus_req", 32'(bus_req_be), 32'd0);
    check("rst_stall", 32'(stall_be), 32'd0);
    check("rst_bus_addr", bus_addr_be, 32'h0);
    check("rst_bus_sel", 32'(bus_sel_be), 32'h0);

    dest_data_in = 32'h1234_5678; dest_addr_in = 5'd7; wreg_in = 1'b1;
    #1;
    check("pass_data", dest_be, 32'h1234_5678);
    check("pass_wreg", 32'(wreg_be), 32'd1);
    check("pass_stall", 32'(stall_be), 32'd0);
    tick();

    // LW with two wait states
    run_op(EXE_LW_OP, 32'h100, 32'h0, 2, 32'hDEAD_BEEF);
    check("lw_stall_cycles", 32'(c_stall), 32'd4);
    check("lw_req_cycles", 32'(c_req), 32'd3);
    check("lw_sel", 32'(c_sel_be), 32'hF);
    check("lw_we", 32'(c_we), 32'd0);
    check("lw_data", r_dest_be, 32'hDEAD_BEEF);
    check("lw_wreg", 32'(r_wreg), 32'd1);
    check("idle_after_lw", 32'(bus_req_be), 32'd0);

    // LB byte 3: BE lane 0, LE lane 3
    run_op(EXE_LB_OP, 32'h103, 32'h0, 0, 32'h7F00_00F0);
    check("lb_stall_cycles", 32'(c_stall), 32'd2);
    check("lb_sel_be", 32'(c_sel_be), 32'h1);
    check("lb_sel_le", 32'(c_sel_le), 32'h8);
    check("lb_data_be", r_dest_be, 32'hFFFF_FFF0);
    check("lb_data_le", r_dest_le, 32'h0000_007F);

    // Misaligned halfword load
    run_op(EXE_LH_OP, 32'h101, 32'h0, 0, 32'h0);
    check("lh_adel", 32'(r_adel), 32'd1);
    check("lh_bad", r_bad, 32'h101);
    check("lh_no_req", 32'(c_req), 32'd0);
    check("lh_wreg", 32'(r_wreg), 32'd0);

    // Misaligned word store
    run_op(EXE_SW_OP, 32'h202, 32'h0, 0, 32'h0);
    check("sw_ades", 32'(r_ades), 32'd1);
    check("sw_adel", 32'(r_adel), 32'd0);
    check("sw_bad", r_bad, 32'h202);
    check("sw_mis_no_req", 32'(c_req), 32'd0);

    // Aligned word store
    run_op(EXE_SW_OP, 32'h204, 32'hCAFE_BABE, 0, 32'h0);
    check("sw_we", 32'(c_we), 32'd1);
    check("sw_wdata", c_wdata_be, 32'hCAFE_BABE);
    check("sw_addr", c_addr, 32'h204);
    check("sw_no_exc", 32'(r_ades), 32'd0);

    // Byte store replication and lane select
    run_op(EXE_SB_OP, 32'h201, 32'h0000_00A5, 0, 32'h0);
    check("sb_wdata", c_wdata_be, 32'hA5A5_A5A5);
    check("sb_sel_be", 32'(c_sel_be), 32'h4);
    check("sb_sel_le", 32'(c_sel_le), 32'h2);

    // Unaligned-word load merge
    run_op(EXE_LWL_OP, 32'h202, 32'h1122_3344, 0, 32'hAABB_CCDD);
    check("lwl_addr", c_addr, 32'h200);
    check("lwl_sel_be", 32'(c_sel_be), 32'h3);
    check("lwl_sel_le", 32'(c_sel_le), 32'h7);
    check("lwl_data_be", r_dest_be, 32'hCCDD_3344);
    check("lwl_data_le", r_dest_le, 32'hBBCC_DD44);

    // Unaligned-word store shift
    run_op(EXE_SWL_OP, 32'h201, 32'h1122_3344, 0, 32'h0);
    check("swl_wdata_be", c_wdata_be, 32'h0011_2233);
    check("swl_wdata_le", c_wdata_le, 32'h0000_1122);
    check("swl_sel_be", 32'(c_sel_be), 32'h7);

    // LL sets the link bit
    run_op(EXE_LL_OP, 32'h300, 32'h0, 1, 32'h1234_5678);
    check("ll_data", r_dest_be, 32'h1234_5678);
    check("ll_llwe", 32'(r_llwe), 32'd1);
    check("ll_lldata", 32'(r_lldata), 32'd1);

    // SC fails: write-back clears the link bit in flight
    llbit_in = 1'b1; wb_llbit_we_in = 1'b1; wb_llbit_data_in = 1'b0;
    run_op(EXE_SC_OP, 32'h300, 32'h55, 0, 32'h0);
    check("scf_no_req", 32'(c_req), 32'd0);
    check("scf_stall", 32'(c_stall), 32'd0);
    check("scf_data", r_dest_be, 32'h0);

    // SC succeeds with link bit set
    wb_llbit_we_in = 1'b0;
    run_op(EXE_SC_OP, 32'h300, 32'h55, 0, 32'h0);
    check("sc_req", 32'(c_req), 32'd1);
    check("sc_wdata", c_wdata_be, 32'h55);
    check("sc_data", r_dest_be, 32'h1);
    check("sc_llwe", 32'(r_llwe), 32'd1);
    check("sc_lldata", 32'(r_lldata), 32'd0);
    llbit_in = 1'b0;

    // Bus timeout
    run_op(EXE_SW_OP, 32'h400, 32'h9, 100, 32'h0);
    check("to_req_cycles", 32'(c_req), 32'd4);
    check("to_bus_err", 32'(r_buserr), 32'd1);
    check("to_bad", r_bad, 32'h400);
    check("to_wreg", 32'(r_wreg), 32'd0);
    #1;
    check("to_idle", 32'(bus_req_be), 32'd0);
    check("to_err_clear", 32'(buserr_be), 32'd0);
    tick();

    // Reset in the middle of REQ
    aluop_in = EXE_LW_OP; mem_addr_in = 32'h500;
    tick();
    check("rstreq_req", 32'(bus_req_be), 32'd1);
    rst = 1'b1;
    tick();
    aluop_in = 8'h00;
    #1;
    check("rstreq_drop", 32'(bus_req_be), 32'd0);
    check("rstreq_stall", 32'(stall_be), 32'd0);
    rst = 1'b0;
    tick();
    check("rstreq_no_result", dest_be, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
